// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC request arbiter: default widths,
// drain FSM encoding and a constant clog2 helper.
package cordic_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_XYWIDTH = 16;
    localparam int DEF_ZWIDTH  = 32;
    localparam int DEF_STAGE   = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Ceiling log2, never below one bit so every derived vector stays legal.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int p = 1; p < value; p = p * 2) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/cordic_arb_rr.sv
// Round-robin grant: the first requester strictly after i_ptr (wrapping) wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant
);

    int w_dist;
    int w_best;

    // Distance 0 is the slot right after the pointer; smallest distance wins.
    always_comb begin
        o_grant = '0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(i_ptr)) % NREQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_arb.sv
// Shares one non-stalling CORDIC pipeline between NREQ requesters, tags each
// operation so its result is returned to the issuer, and supports draining.
module cordic_arb
    import cordic_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int XYWIDTH = DEF_XYWIDTH,
    parameter int ZWIDTH  = DEF_ZWIDTH,
    parameter int STAGE   = DEF_STAGE,
    parameter int TAGW    = clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ZWIDTH-1:0]  req_z,
    input  logic [NREQ*XYWIDTH-1:0] req_x,
    input  logic [NREQ*XYWIDTH-1:0] req_y,
    output logic [ZWIDTH-1:0]       cdc_z0,
    output logic [XYWIDTH-1:0]      cdc_x0,
    output logic [XYWIDTH-1:0]      cdc_y0,
    input  logic [XYWIDTH:0]        cdc_xout,
    input  logic [XYWIDTH:0]        cdc_yout,
    output logic                    res_valid,
    output logic [TAGW-1:0]         res_tag,
    output logic [XYWIDTH:0]        res_x,
    output logic [XYWIDTH:0]        res_y,
    input  logic                    drain,
    output logic                    drain_done,
    output logic                    busy
);

    localparam int CW = clog2(STAGE + 1);

    state_t           r_state;
    logic [TAGW-1:0]  r_ptr;
    logic [STAGE-1:0] r_vld;
    logic [TAGW-1:0]  r_tag [STAGE];
    logic [CW-1:0]    r_count;
    logic             r_res_valid;
    logic [TAGW-1:0]  r_res_tag;
    logic [XYWIDTH:0] r_res_x;
    logic [XYWIDTH:0] r_res_y;
    logic             r_drain_done;

    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_ready;
    logic               w_hs;
    logic               w_retire;
    logic [TAGW-1:0]    w_hs_tag;
    logic [ZWIDTH-1:0]  w_z_m [NREQ];
    logic [XYWIDTH-1:0] w_x_m [NREQ];
    logic [XYWIDTH-1:0] w_y_m [NREQ];

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (TAGW)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    // Grants only in RUN; any valid&ready bit is the handshake itself.
    assign w_ready  = (r_state == ST_RUN) ? w_grant : '0;
    assign w_hs     = |w_ready;
    assign w_retire = r_vld[STAGE-1];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
            assign w_z_m[gi] = w_ready[gi] ? req_z[gi*ZWIDTH +: ZWIDTH]   : '0;
            assign w_x_m[gi] = w_ready[gi] ? req_x[gi*XYWIDTH +: XYWIDTH] : '0;
            assign w_y_m[gi] = w_ready[gi] ? req_y[gi*XYWIDTH +: XYWIDTH] : '0;
        end
    endgenerate

    always_comb begin
        cdc_z0   = '0;
        cdc_x0   = '0;
        cdc_y0   = '0;
        w_hs_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            cdc_z0 = cdc_z0 | w_z_m[i];
            cdc_x0 = cdc_x0 | w_x_m[i];
            cdc_y0 = cdc_y0 | w_y_m[i];
            if (w_ready[i]) begin
                w_hs_tag = w_hs_tag | TAGW'(i);
            end
        end
    end

    // Tracking shift register mirrors the CORDIC stages one-for-one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= '0;
            for (int s = 0; s < STAGE; s++) begin
                r_tag[s] <= '0;
            end
            r_ptr       <= TAGW'(NREQ - 1);
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_x     <= '0;
            r_res_y     <= '0;
        end else begin
            for (int s = STAGE - 1; s > 0; s--) begin
                r_vld[s] <= r_vld[s-1];
                r_tag[s] <= r_tag[s-1];
            end
            r_vld[0] <= w_hs;
            r_tag[0] <= w_hs_tag;
            if (w_hs) begin
                r_ptr <= w_hs_tag;
            end
            r_res_valid <= w_retire;
            if (w_retire) begin
                r_res_tag <= r_tag[STAGE-1];
                r_res_x   <= cdc_xout;
                r_res_y   <= cdc_yout;
            end
            case ({w_hs, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // DRAIN waits until the last result has also been presented on res_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_drain_done <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (drain) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((r_count == '0) && !r_res_valid) begin
                        r_state      <= ST_DONE;
                        r_drain_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_drain_done <= 1'b0;
                    r_state      <= drain ? ST_HOLD : ST_RUN;
                end
                ST_HOLD: begin
                    if (!drain) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign res_valid  = r_res_valid;
    assign res_tag    = r_res_tag;
    assign res_x      = r_res_x;
    assign res_y      = r_res_y;
    assign drain_done = r_drain_done;
    assign busy       = (r_count != '0);

endmodule

// File: tb/tb_cordic_arb.sv
// Self-checking bench for cordic_arb: a behavioural CORDIC stand-in feeds the
// DUT, a queue-based model is compared every cycle, plus literal scenario checks.
module tb_cordic_arb;

    localparam int NREQ    = 4;
    localparam int XYWIDTH = 16;
    localparam int ZWIDTH  = 32;
    localparam int STAGE   = 16;
    localparam int TAGW    = 2;
    localparam real KGAIN  = 1.646760258;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2, M_HOLD = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*ZWIDTH-1:0]  req_z;
    logic [NREQ*XYWIDTH-1:0] req_x;
    logic [NREQ*XYWIDTH-1:0] req_y;
    logic [ZWIDTH-1:0]       cdc_z0;
    logic [XYWIDTH-1:0]      cdc_x0;
    logic [XYWIDTH-1:0]      cdc_y0;
    logic [XYWIDTH:0]        cdc_xout;
    logic [XYWIDTH:0]        cdc_yout;
    logic                    res_valid;
    logic [TAGW-1:0]         res_tag;
    logic [XYWIDTH:0]        res_x;
    logic [XYWIDTH:0]        res_y;
    logic                    drain;
    logic                    drain_done;
    logic                    busy;

    cordic_arb #(
        .NREQ(NREQ), .XYWIDTH(XYWIDTH), .ZWIDTH(ZWIDTH), .STAGE(STAGE), .TAGW(TAGW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_z(req_z), .req_x(req_x), .req_y(req_y),
        .cdc_z0(cdc_z0), .cdc_x0(cdc_x0), .cdc_y0(cdc_y0),
        .cdc_xout(cdc_xout), .cdc_yout(cdc_yout),
        .res_valid(res_valid), .res_tag(res_tag), .res_x(res_x), .res_y(res_y),
        .drain(drain), .drain_done(drain_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic ok, input longint act, input longint expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    // Rotation by z (full circle = 2^32) with the CORDIC gain, truncated.
    function automatic int fcordic(input logic [31:0] z, input logic [15:0] x,
                                   input logic [15:0] y, input bit want_y);
        real a, xr, yr;
        a  = 6.283185307179586 * (real'(z[31:16]) * 65536.0 + real'(z[15:0])) / 4294967296.0;
        xr = real'($signed(x));
        yr = real'($signed(y));
        if (want_y) return $rtoi(KGAIN * (yr * $cos(a) + xr * $sin(a)));
        return $rtoi(KGAIN * (xr * $cos(a) - yr * $sin(a)));
    endfunction

    logic [XYWIDTH:0] d_x [STAGE];
    logic [XYWIDTH:0] d_y [STAGE];
    always @(posedge clk) begin
        for (int i = STAGE - 1; i > 0; i--) begin
            d_x[i] <= d_x[i-1];
            d_y[i] <= d_y[i-1];
        end
        d_x[0] <= 17'(fcordic(cdc_z0, cdc_x0, cdc_y0, 1'b0));
        d_y[0] <= 17'(fcordic(cdc_z0, cdc_x0, cdc_y0, 1'b1));
    end
    assign cdc_xout = d_x[STAGE-1];
    assign cdc_yout = d_y[STAGE-1];

    typedef struct { int due; int tag; int x; int y; } exp_t;
    typedef struct { int idx; int cyc; } glog_t;
    typedef struct { int tag; int x; int y; int cyc; } rlog_t;

    exp_t  exp_q[$];
    glog_t glog[$];
    rlog_t rlog[$];
    int    cyc    = 0;
    int    dd_cnt = 0;
    int    dd_cyc = -1;
    int    m_mode = M_RUN;
    int    m_ptr  = NREQ - 1;

    int          g, c, inflight, obs;
    logic        exp_rv;
    exp_t        e;
    logic [3:0]  er;
    logic [31:0] ez;
    logic [15:0] ex, ey;

    // Model sees inputs held from posedge+1 to the next posedge, so it both
    // checks this cycle and advances to the state after the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode = M_RUN;
            m_ptr  = NREQ - 1;
            exp_q.delete();
        end
        exp_rv = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_rv = 1'b1;
            e = exp_q.pop_front();
        end
        inflight = exp_q.size();
        chk($sformatf("res_valid@%0d", cyc), res_valid == exp_rv, res_valid, exp_rv);
        if (exp_rv) begin
            chk($sformatf("res_tag@%0d", cyc), int'(res_tag) == e.tag, res_tag, e.tag);
            chk($sformatf("res_x@%0d", cyc), int'($signed(res_x)) == e.x, $signed(res_x), e.x);
            chk($sformatf("res_y@%0d", cyc), int'($signed(res_y)) == e.y, $signed(res_y), e.y);
        end
        chk($sformatf("busy@%0d", cyc), busy == (inflight != 0), busy, inflight != 0);
        chk($sformatf("drain_done@%0d", cyc), drain_done == (m_mode == M_DONE), drain_done, m_mode == M_DONE);

        g = -1;
        if (m_mode == M_RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        ez = '0; ex = '0; ey = '0;
        if (g >= 0) begin
            ez = req_z[g*ZWIDTH +: ZWIDTH];
            ex = req_x[g*XYWIDTH +: XYWIDTH];
            ey = req_y[g*XYWIDTH +: XYWIDTH];
        end
        chk($sformatf("req_ready@%0d", cyc), req_ready == er, req_ready, er);
        chk($sformatf("cdc_z0@%0d", cyc), cdc_z0 == ez, cdc_z0, ez);
        chk($sformatf("cdc_x0@%0d", cyc), cdc_x0 == ex, cdc_x0, ex);
        chk($sformatf("cdc_y0@%0d", cyc), cdc_y0 == ey, cdc_y0, ey);

        obs = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs = i;
        if (obs >= 0 && rst_n) glog.push_back('{idx: obs, cyc: cyc});
        if (res_valid) rlog.push_back('{tag: int'(res_tag), x: int'($signed(res_x)),
                                         y: int'($signed(res_y)), cyc: cyc});
        if (drain_done) begin
            dd_cnt++;
            dd_cyc = cyc;
        end

        if (rst_n) begin
            if (g >= 0) begin
                exp_q.push_back('{due: cyc + 1 + STAGE, tag: g,
                                  x: fcordic(ez, ex, ey, 1'b0), y: fcordic(ez, ex, ey, 1'b1)});
                m_ptr = g;
            end
            case (m_mode)
                M_RUN:   if (drain) m_mode = M_DRAIN;
                M_DRAIN: if (inflight == 0 && !exp_rv) m_mode = M_DONE;
                M_DONE:  m_mode = drain ? M_HOLD : M_RUN;
                default: if (!drain) m_mode = M_RUN;
            endcase
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] z, input int x, input int y);
        req_z[i*ZWIDTH +: ZWIDTH]   = z;
        req_x[i*XYWIDTH +: XYWIDTH] = 16'(x);
        req_y[i*XYWIDTH +: XYWIDTH] = 16'(y);
    endtask

    task automatic clear_logs();
        glog.delete();
        rlog.delete();
        dd_cnt = 0;
        dd_cyc = -1;
    endtask

    function automatic int gidx(input int j);
        return (j < glog.size()) ? glog[j].idx : -1;
    endfunction

    function automatic int rtag(input int j);
        return (j < rlog.size()) ? rlog[j].tag : -1;
    endfunction

    function automatic int rcyc(input int j);
        return (j < rlog.size()) ? rlog[j].cyc : -1;
    endfunction

    int c0;

    initial begin
        rst_n = 1'b0; drain = 1'b0; req_valid = '0;
        req_z = '0; req_x = '0; req_y = '0;
        tick(3);
        chk("reset_busy", busy == 1'b0, busy, 0);
        chk("reset_res_valid", res_valid == 1'b0, res_valid, 0);
        chk("reset_drain_done", drain_done == 1'b0, drain_done, 0);
        chk("reset_res_x", res_x == '0, res_x, 0);
        rst_n = 1'b1;
        tick(2);

        // Single request from requester 2, z=0, x=1000, y=0
        clear_logs();
        set_req(2, 32'd0, 1000, 0);
        req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        tick(STAGE + 4);
        chk("t1_grants", glog.size() == 1, glog.size(), 1);
        chk("t1_gidx", gidx(0) == 2, gidx(0), 2);
        chk("t1_results", rlog.size() == 1, rlog.size(), 1);
        chk("t1_tag", rtag(0) == 2, rtag(0), 2);
        chk("t1_x", rlog.size() > 0 && rlog[0].x == 1646, (rlog.size() > 0) ? rlog[0].x : -1, 1646);
        chk("t1_y", rlog.size() > 0 && rlog[0].y == 0, (rlog.size() > 0) ? rlog[0].y : -1, 0);
        chk("t1_latency", rcyc(0) - (glog.size() > 0 ? glog[0].cyc : 0) == STAGE + 1,
            rcyc(0) - (glog.size() > 0 ? glog[0].cyc : 0), STAGE + 1);

        // All four requesters from reset for 8 cycles
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i) << 30, 100 * (i + 1), 50 * i);
        req_valid = 4'b1111;
        tick(8);
        req_valid = '0;
        tick(STAGE + 4);
        chk("t2_grants", glog.size() == 8, glog.size(), 8);
        chk("t2_results", rlog.size() == 8, rlog.size(), 8);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t2_grant%0d", j), gidx(j) == j % 4, gidx(j), j % 4);
            chk($sformatf("t2_tag%0d", j), rtag(j) == j % 4, rtag(j), j % 4);
            chk($sformatf("t2_b2b%0d", j), rcyc(j) == rcyc(0) + j, rcyc(j), rcyc(0) + j);
        end

        // Only requesters 1 and 3 valid
        clear_logs();
        req_valid = 4'b1010;
        tick(8);
        req_valid = '0;
        tick(STAGE + 4);
        chk("t3_grants", glog.size() == 8, glog.size(), 8);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t3_grant%0d", j), gidx(j) == ((j % 2 == 1) ? 3 : 1), gidx(j), (j % 2 == 1) ? 3 : 1);
        end

        // Drain with 5 operations in flight; drain held into HOLD
        clear_logs();
        req_valid = 4'b1111;
        tick(4);
        drain = 1'b1;
        tick(1);
        chk("t4_ready_off", req_ready == '0, req_ready, 0);
        for (int n = 0; n < 100 && !drain_done; n++) tick(1);
        chk("t4_done_seen", drain_done == 1'b1, drain_done, 1);
        chk("t4_busy_idle", busy == 1'b0, busy, 0);
        tick(1);
        chk("t4_pulse_end", drain_done == 1'b0, drain_done, 0);
        chk("t4_hold_nogrant", req_ready == '0, req_ready, 0);
        tick(2);
        chk("t4_grants", glog.size() == 5, glog.size(), 5);
        chk("t4_results", rlog.size() == 5, rlog.size(), 5);
        chk("t4_pulses", dd_cnt == 1, dd_cnt, 1);
        drain = 1'b0;
        req_valid = '0;
        tick(3);

        // Drain on an empty pipeline
        clear_logs();
        c0 = cyc;
        drain = 1'b1;
        tick(1);
        drain = 1'b0;
        tick(4);
        chk("t5_pulses", dd_cnt == 1, dd_cnt, 1);
        chk("t5_done_cycle", dd_cyc == c0 + 2, dd_cyc, c0 + 2);

        // Reset with 10 operations in flight
        req_valid = 4'b1111;
        tick(10);
        rst_n = 1'b0;
        req_valid = '0;
        tick(1);
        rst_n = 1'b1;
        clear_logs();
        tick(STAGE + 6);
        chk("t6_no_results", rlog.size() == 0, rlog.size(), 0);
        chk("t6_busy", busy == 1'b0, busy, 0);
        req_valid = 4'b1111;
        tick(1);
        req_valid = '0;
        tick(2);
        chk("t6_first_grant", gidx(0) == 0, gidx(0), 0);

        // Random traffic; the per-cycle model tracks the in-flight count
        for (int n = 0; n < 50; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, $urandom(), int'($urandom_range(0, 4000)) - 2000,
                        int'($urandom_range(0, 4000)) - 2000);
            req_valid = 4'($urandom_range(0, 15));
            tick(1);
        end
        req_valid = '0;
        tick(STAGE + 4);
        chk("t7_busy_end", busy == 1'b0, busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
